// File: rtl/coin_acceptor_if.sv
// Coin-path signals between the chute sensors / machine control and the coin acceptor.
interface coin_acceptor_if #(
    parameter int CNT_W = 8
);
    logic             sense_5;
    logic             sense_10;
    logic             inhibit;
    logic [1:0]       coin;
    logic             reject;
    logic [CNT_W-1:0] coin_count;
    logic             busy;

    modport master (
        output sense_5, sense_10, inhibit,
        input  coin, reject, coin_count, busy
    );

    modport slave (
        input  sense_5, sense_10, inhibit,
        output coin, reject, coin_count, busy
    );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronises and debounces the two chute sensors and emits one coin code or reject per insertion.
// state        | meaning
// IDLE         | no insertion in progress, waiting for a nonzero sample
// DEBOUNCE     | candidate captured, counting consecutive matching samples
// WAIT_RELEASE | insertion classified, waiting for a qualified all-clear
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic             clk,
    input logic             rst,
    coin_acceptor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE} state_t;

    localparam logic [7:0]       DB_LEN  = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [1:0]       sync_1, s;
    logic [1:0]       cand, cand_nx;
    logic [7:0]       cnt, cnt_nx, cnt_inc;
    logic             classify;
    logic [1:0]       coin_q, coin_nx;
    logic             reject_q, reject_nx;
    logic [CNT_W-1:0] count_q, count_nx;
    logic             busy_q;

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1   <= 2'b00;
            s        <= 2'b00;
            state    <= IDLE;
            cand     <= 2'b00;
            cnt      <= 8'd0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            sync_1   <= {bus.sense_10, bus.sense_5};
            s        <= sync_1;
            state    <= state_nx;
            cand     <= cand_nx;
            cnt      <= cnt_nx;
            coin_q   <= coin_nx;
            reject_q <= reject_nx;
            count_q  <= count_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        classify = 1'b0;
        case (state)
            IDLE: begin
                if (s != 2'b00) begin
                    cand_nx = s;
                    // A one-sample debounce qualifies on the capture edge itself.
                    if (DB_LEN == 8'd1) begin
                        classify = 1'b1;
                        cnt_nx   = 8'd0;
                        state_nx = WAIT_RELEASE;
                    end else begin
                        cnt_nx   = 8'd1;
                        state_nx = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (s != cand) begin
                    cnt_nx   = 8'd0;
                    state_nx = IDLE;
                end else if (cnt_inc == DB_LEN) begin
                    classify = 1'b1;
                    cnt_nx   = 8'd0;
                    state_nx = WAIT_RELEASE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            WAIT_RELEASE: begin
                if (s != 2'b00) begin
                    cnt_nx = 8'd0;
                end else if (cnt_inc == DB_LEN) begin
                    cnt_nx   = 8'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                cnt_nx   = 8'd0;
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        coin_nx   = 2'b00;
        reject_nx = 1'b0;
        count_nx  = count_q;
        if (classify) begin
            if (cand_nx == 2'b11 || bus.inhibit) begin
                reject_nx = 1'b1;
            end else begin
                coin_nx = cand_nx;
                if (count_q != CNT_MAX)
                    count_nx = count_q + 1'b1;
            end
        end
    end

    assign bus.coin       = coin_q;
    assign bus.reject     = reject_q;
    assign bus.coin_count = count_q;
    assign bus.busy       = busy_q;
endmodule
